// File: rtl/conv_accum.sv
// Channel accumulator and post-processing stage for the convolution unit.
// Sums bias plus per-channel partial sums, then rounds, shifts, applies ReLU and saturates.
module conv_accum #(
   parameter int WIDTH     = 9,
   parameter int ACC_WIDTH = 24
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic signed [2*WIDTH-1:0]   in_sum,
   input  logic                        in_last,
   input  logic signed [2*WIDTH-1:0]   bias,
   input  logic [4:0]                  shift,
   input  logic                        relu_en,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [WIDTH-1:0]     out_data,
   output logic                        ovf,
   output logic [15:0]                 beat_cnt
);

   localparam int SW = 2 * WIDTH;

   localparam logic signed [ACC_WIDTH:0] ACC_MAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH:0] ACC_MIN = ~ACC_MAX;
   localparam logic signed [ACC_WIDTH:0] OUT_MAX = {{(ACC_WIDTH-WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH:0] OUT_MIN = ~OUT_MAX;
   localparam logic signed [ACC_WIDTH:0] ONE_W   = {{ACC_WIDTH{1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_ACCUM = 1'b1
   } state_t;

   state_t                      state_r;
   state_t                      state_nxt_s;
   logic signed [ACC_WIDTH-1:0] acc_r;
   logic [15:0]                 beat_cnt_r;
   logic                        out_valid_r;
   logic signed [WIDTH-1:0]     out_data_r;
   logic                        ovf_r;

   logic                        accept_s;
   logic signed [ACC_WIDTH:0]   base_s;
   logic signed [ACC_WIDTH:0]   sum_w_s;
   logic signed [ACC_WIDTH-1:0] acc_sat_s;
   logic                        sat_hit_s;
   logic [15:0]                 cnt_nxt_s;

   function automatic logic signed [ACC_WIDTH-1:0] sat_acc(input logic signed [ACC_WIDTH:0] x);
      logic signed [ACC_WIDTH:0] y;
      if (x > ACC_MAX) begin
         y = ACC_MAX;
      end else if (x < ACC_MIN) begin
         y = ACC_MIN;
      end else begin
         y = x;
      end
      return y[ACC_WIDTH-1:0];
   endfunction

   // Round half-up without wrap, arithmetic shift, optional ReLU, clamp to the activation range.
   function automatic logic signed [WIDTH-1:0] post_proc(input logic signed [ACC_WIDTH-1:0] x,
                                                         input logic [4:0] sh,
                                                         input logic relu);
      logic signed [ACC_WIDTH:0] half;
      logic signed [ACC_WIDTH:0] rnd;
      logic signed [ACC_WIDTH:0] shd;
      if (sh != 5'd0) begin
         half = ONE_W << (sh - 5'd1);
      end else begin
         half = '0;
      end
      rnd = {x[ACC_WIDTH-1], x} + half;
      shd = rnd >>> sh;
      if (relu && shd[ACC_WIDTH]) begin
         shd = '0;
      end else if (shd > OUT_MAX) begin
         shd = OUT_MAX;
      end else if (shd < OUT_MIN) begin
         shd = OUT_MIN;
      end else begin
         shd = shd;
      end
      return shd[WIDTH-1:0];
   endfunction

   // Handshake and accumulator datapath (combinational).
   always_comb begin
      in_ready = !out_valid_r || out_ready;
      accept_s = in_valid && in_ready;
      case (state_r)
         ST_EMPTY: begin
            base_s    = {{(ACC_WIDTH+1-SW){bias[SW-1]}}, bias};
            cnt_nxt_s = 16'd1;
         end
         ST_ACCUM: begin
            base_s    = {acc_r[ACC_WIDTH-1], acc_r};
            cnt_nxt_s = (beat_cnt_r == 16'hFFFF) ? 16'hFFFF : beat_cnt_r + 16'd1;
         end
         default: begin
            base_s    = '0;
            cnt_nxt_s = 16'd0;
         end
      endcase
      sum_w_s   = base_s + {{(ACC_WIDTH+1-SW){in_sum[SW-1]}}, in_sum};
      acc_sat_s = sat_acc(sum_w_s);
      sat_hit_s = sum_w_s[ACC_WIDTH] != sum_w_s[ACC_WIDTH-1];
   end

   // Next-state logic: a last beat always closes the group.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_EMPTY: begin
            if (accept_s && !in_last) begin
               state_nxt_s = ST_ACCUM;
            end else begin
               state_nxt_s = ST_EMPTY;
            end
         end
         ST_ACCUM: begin
            if (accept_s && in_last) begin
               state_nxt_s = ST_EMPTY;
            end else begin
               state_nxt_s = ST_ACCUM;
            end
         end
         default: state_nxt_s = ST_EMPTY;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_EMPTY;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Accumulator, beat counter, output register and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_r       <= '0;
         beat_cnt_r  <= 16'd0;
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         ovf_r       <= 1'b0;
      end else begin
         if (accept_s && in_last) begin
            acc_r       <= '0;
            beat_cnt_r  <= 16'd0;
            out_data_r  <= post_proc(acc_sat_s, shift, relu_en);
            out_valid_r <= 1'b1;
         end else begin
            if (accept_s) begin
               acc_r      <= acc_sat_s;
               beat_cnt_r <= cnt_nxt_s;
            end
            if (out_ready) begin
               out_valid_r <= 1'b0;
            end
         end
         if (accept_s && sat_hit_s) begin
            ovf_r <= 1'b1;
         end
      end
   end

   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign ovf       = ovf_r;
   assign beat_cnt  = beat_cnt_r;

endmodule

// File: tb/tb_conv_accum.sv
// Directed self-checking bench for conv_accum with hand-computed expected values.
module tb_conv_accum;

   localparam int WIDTH = 9;
   localparam int ACC_WIDTH = 24;

   logic                      clk;
   logic                      rst;
   logic                      in_valid;
   logic                      in_ready;
   logic signed [2*WIDTH-1:0] in_sum;
   logic                      in_last;
   logic signed [2*WIDTH-1:0] bias;
   logic [4:0]                shift;
   logic                      relu_en;
   logic                      out_valid;
   logic                      out_ready;
   logic signed [WIDTH-1:0]   out_data;
   logic                      ovf;
   logic [15:0]               beat_cnt;

   int checks_cnt = 0;
   int fail_cnt = 0;

   conv_accum #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_sum(in_sum), .in_last(in_last), .bias(bias), .shift(shift),
      .relu_en(relu_en), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .ovf(ovf), .beat_cnt(beat_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int obs, input int exp);
      checks_cnt++;
      if (obs !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One accepted beat; inputs change 1 time unit after the edge.
   task automatic send(input int s, input bit last, input int b, input int sh, input bit relu);
      in_valid = 1'b1;
      in_sum   = 18'(s);
      in_last  = last;
      bias     = 18'(b);
      shift    = 5'(sh);
      relu_en  = relu;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_last = 1'b0; bias = '0;
      shift = 5'd0; relu_en = 1'b0; out_ready = 1'b1;
      idle(3);
      rst = 1'b0;
      #1;
      check_val("rst_out_valid", int'(out_valid), 0);
      check_val("rst_out_data", int'(out_data), 0);
      check_val("rst_ovf", int'(ovf), 0);
      check_val("rst_beat_cnt", int'(beat_cnt), 0);
      check_val("rst_in_ready", int'(in_ready), 1);

      // Basic group: 10 + 100 + 200 - 50 = 260, (260 + 2) >> 2 = 65
      send(100, 1'b0, 10, 0, 1'b1);
      check_val("basic_cnt1", int'(beat_cnt), 1);
      send(200, 1'b0, 0, 0, 1'b1);
      check_val("basic_cnt2", int'(beat_cnt), 2);
      check_val("basic_no_out", int'(out_valid), 0);
      send(-50, 1'b1, 0, 2, 1'b1);
      check_val("basic_valid", int'(out_valid), 1);
      check_val("basic_data", int'(out_data), 65);
      check_val("basic_cnt0", int'(beat_cnt), 0);
      idle(1);
      check_val("basic_drained", int'(out_valid), 0);

      // ReLU and negative saturation
      send(-400, 1'b1, 0, 0, 1'b1);
      check_val("relu_zero", int'(out_data), 0);
      send(-400, 1'b1, 0, 0, 1'b0);
      check_val("neg_sat", int'(out_data), -256);

      // Positive saturation and rounding
      send(30000, 1'b1, 0, 4, 1'b0);
      check_val("pos_sat", int'(out_data), 255);
      send(24, 1'b1, 0, 4, 1'b0);
      check_val("round_up", int'(out_data), 2);
      check_val("round_valid", int'(out_valid), 1);
      idle(1);

      // Backpressure: hold result 65, offer a single-beat group 2 (value 40)
      send(100, 1'b0, 10, 0, 1'b1);
      send(200, 1'b0, 0, 0, 1'b1);
      out_ready = 1'b0;
      send(-50, 1'b1, 0, 2, 1'b1);
      check_val("bp_data0", int'(out_data), 65);
      in_valid = 1'b1; in_sum = 18'sd40; in_last = 1'b1; bias = '0; shift = 5'd0; relu_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         check_val("bp_in_ready", int'(in_ready), 0);
         @(posedge clk);
         #1;
         check_val("bp_valid", int'(out_valid), 1);
         check_val("bp_data", int'(out_data), 65);
         check_val("bp_cnt", int'(beat_cnt), 0);
      end
      out_ready = 1'b1;
      #1;
      check_val("bp_ready_back", int'(in_ready), 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_last = 1'b0;
      check_val("bp_g2_valid", int'(out_valid), 1);
      check_val("bp_g2_data", int'(out_data), 40);
      idle(1);
      check_val("bp_g2_drained", int'(out_valid), 0);

      // Accumulator overflow: 300 beats of +32767 pin acc at 8388607
      check_val("pre_ovf", int'(ovf), 0);
      for (int i = 0; i < 299; i++) begin
         send(32767, 1'b0, 0, 0, 1'b0);
      end
      check_val("acc_pinned", int'(dut.acc_r), 8388607);
      check_val("ovf_set", int'(ovf), 1);
      check_val("ovf_cnt", int'(beat_cnt), 299);
      send(32767, 1'b1, 0, 16, 1'b0);
      check_val("ovf_data", int'(out_data), 128);
      idle(2);
      check_val("ovf_sticky", int'(ovf), 1);

      // Reset mid-group discards the partial sum
      send(100, 1'b0, 0, 0, 1'b0);
      send(100, 1'b0, 0, 0, 1'b0);
      send(100, 1'b0, 0, 0, 1'b0);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      check_val("mid_rst_valid", int'(out_valid), 0);
      check_val("mid_rst_cnt", int'(beat_cnt), 0);
      check_val("mid_rst_ovf", int'(ovf), 0);
      idle(1);
      check_val("mid_rst_no_out", int'(out_valid), 0);
      send(7, 1'b1, 0, 0, 1'b0);
      check_val("mid_rst_data", int'(out_data), 7);
      check_val("mid_rst_valid2", int'(out_valid), 1);
      check_val("mid_rst_ovf2", int'(ovf), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
      $finish;
   end

endmodule
